dcache_refill_writer: RTL
=========================

# dcache_refill_writer

Write-side counterpart of the 2-way data cache hit read mux. It collects the four 32-bit memory return beats of a missed line, merges any pending store bytes, and issues a one-cycle 128-bit write into the selected way's data array. It sits between the memory return interface and the two way data RAMs, alongside the miss-handling FSM that starts it.

## Interface
Parameters:
- `DATA_W`, default 32: width of one return beat.
- `BEATS`, default 4: beats per line. Line width is `DATA_W*BEATS` = 128.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `refill_start`  in  1  starts a refill; honoured only in IDLE.
- `refill_way`  in  2  target way, sampled at start: `01` = way1, `10` = way2, `11` = way2, `00` = no way.
- `st_valid`  in  1  the miss was a store; merge store bytes into the line. Sampled at start.
- `st_offset`  in  2  word index of the store within the line. Sampled at start.
- `st_wdata`  in  32  store data. Sampled at start.
- `st_wstrb`  in  4  store byte strobes. Sampled at start.
- `ret_valid`  in  1  memory return beat valid.
- `ret_last`  in  1  final beat of the burst.
- `ret_data`  in  32  beat data.
- `busy`  out  1  high in FILL and WRITE.
- `w_en`  out  2  one-hot way write enable; one-cycle pulse.
- `w_data`  out  128  merged line; valid while `w_en` is nonzero or `w_done` is high.
- `w_done`  out  1  one-cycle pulse marking completion of the refill.

## Operation
States:
- **IDLE**
  - `refill_start` captures the start-time inputs, clears the line buffer to 0, clears the beat counter, and moves to FILL.
  - `ret_valid` is ignored.
- **FILL**
  - Each `ret_valid` writes `ret_data` into buffer word `cnt`, at bits `[32*cnt+31 : 32*cnt]`, then increments `cnt`.
  - A `ret_valid` with `ret_last` high, or with `cnt==3`, moves to WRITE.
  - An early `ret_last` leaves the unfilled words at 0.
  - `refill_start` is ignored.
- **WRITE**
  - For exactly one cycle: `w_en` is the decoded way, `w_data` is the merged line, and `w_done` is 1.
  - Moves to IDLE on the next edge.
  - `ret_valid` is ignored, so extra beats after the line completes are dropped.

Way decode (same priority as the hit read mux):
- `01` gives `w_en=01`.
- `10` or `11` gives `w_en=10`.
- `00` gives `w_en=00`; `w_done` still pulses.

Store merge:
- When the captured `st_valid` is set, byte `b` of word `st_offset` is replaced by `st_wdata[8b+7:8b]` wherever `st_wstrb[b]` is 1.
- The merge is applied combinationally on the buffer output during WRITE. Memory data never overwrites store bytes.
- When the captured `st_valid` is clear, `w_data` is the buffer unchanged.

## Timing
- All outputs reset to 0. State resets to IDLE, `cnt` to 0, and the buffer to 0.
- `refill_start` sampled at edge N puts the block in FILL (`busy=1`) from N+1.
- The beat that completes the line (sampled at edge M) gives WRITE during cycle M+1. `w_en`/`w_done` are high in that cycle only, and `busy` is 0 from M+2.
- Minimum refill latency: start, plus 4 beats, plus 1 write cycle.
- Back-to-back: `refill_start` is accepted in the cycle after WRITE. A start asserted during WRITE is ignored.
- Gaps between beats (`ret_valid` low) hold state indefinitely.
- `rst` asserted mid-refill immediately forces IDLE and all outputs to 0. The partial line is discarded and no write is issued.
- `cnt` is 2 bits and never wraps inside FILL, because `cnt==3` with a valid beat always exits.

## Structure
- Shared package `dcache_pkg` holds:
  - state enum `refill_state_t` {IDLE, FILL, WRITE}
  - `LINE_W=128`, `WORD_W=32`, `BEATS=4`
  - way encodings `WAY1=2'b01`, `WAY2=2'b10`
- One sub-module, `dcache_store_merge`: combinational, takes line, offset, wdata, wstrb and enable, and returns the merged line. It is reusable by the store-hit write path.

## Test plan
- Load, way1: start with way `01`, `st_valid=0`, beats `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444` → one-cycle `w_en=01`, `w_data=0x44444444_33333333_22222222_11111111`, `w_done=1`.
- Store merge, way2: start with way `10`, `st_offset=2`, `st_wdata=0xAABBCCDD`, `st_wstrb=0101`, beats all `0x00000000` → `w_en=10`, word2 = `0x00BB00DD`, other words 0.
- Early last and way `11`: two beats `0xA`, `0xB`, the second with `ret_last=1` → `w_en=10`, `w_data=0x0..0_0000000B_0000000A`. A third beat during WRITE is ignored.
- Way `00` and ignored inputs: start with way `00` → `w_en=00` and `w_done=1` after 4 beats. `refill_start` during FILL and `ret_valid` in IDLE cause no state change.
- Reset mid-refill: assert `rst` after 2 beats → `busy=0`, `w_en=00` immediately. A new refill afterwards produces a clean line with no stale words.
- Stalls: beats separated by 0–3 idle cycles, then a back-to-back second refill started the cycle after `w_done` → both lines written correctly, each `w_en` exactly one cycle.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: line geometry, way encodings and refill FSM states.
package dcache_pkg;
    localparam int WORD_W = 32;
    localparam int BEATS  = 4;
    localparam int LINE_W = WORD_W * BEATS;

    localparam logic [1:0] WAY1 = 2'b01;
    localparam logic [1:0] WAY2 = 2'b10;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} refill_state_t;

    // Same priority as the hit read mux: way1 only on an exact 01, any bit 1 selects way2.
    function automatic logic [1:0] way_decode(input logic [1:0] way);
        logic [1:0] en;
        en = 2'b00;
        if (way == WAY1) en = WAY1;
        else if (way[1]) en = WAY2;
        return en;
    endfunction
endpackage

// File: rtl/dcache_refill_writer_if.sv
// Refill writer bus: start/store capture, memory return beats, way write port.
interface dcache_refill_writer_if #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
);
    logic                       refill_start;
    logic [1:0]                 refill_way;
    logic                       st_valid;
    logic [$clog2(BEATS)-1:0]   st_offset;
    logic [DATA_W-1:0]          st_wdata;
    logic [DATA_W/8-1:0]        st_wstrb;
    logic                       ret_valid;
    logic                       ret_last;
    logic [DATA_W-1:0]          ret_data;
    logic                       busy;
    logic [1:0]                 w_en;
    logic [DATA_W*BEATS-1:0]    w_data;
    logic                       w_done;

    modport master (
        output refill_start, refill_way, st_valid, st_offset, st_wdata, st_wstrb,
               ret_valid, ret_last, ret_data,
        input  busy, w_en, w_data, w_done
    );

    modport slave (
        input  refill_start, refill_way, st_valid, st_offset, st_wdata, st_wstrb,
               ret_valid, ret_last, ret_data,
        output busy, w_en, w_data, w_done
    );
endinterface

// File: rtl/dcache_store_merge.sv
// Combinational byte-strobed store merge of one word into a cache line.
module dcache_store_merge #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic [WORDS-1:0][WORD_W-1:0] line_i,
    input  logic [$clog2(WORDS)-1:0]     offset_i,
    input  logic [WORD_W-1:0]            wdata_i,
    input  logic [WORD_W/8-1:0]          wstrb_i,
    input  logic                         en_i,
    output logic [WORDS-1:0][WORD_W-1:0] line_o
);
    for (genvar w = 0; w < WORDS; w++) begin : g_word
        for (genvar b = 0; b < WORD_W/8; b++) begin : g_byte
            logic hit;
            assign hit = en_i && (offset_i == ($clog2(WORDS))'(w)) && wstrb_i[b];
            assign line_o[w][8*b +: 8] = hit ? wdata_i[8*b +: 8] : line_i[w][8*b +: 8];
        end
    end
endmodule

// File: rtl/dcache_refill_writer.sv
// Collects a missed line's return beats, merges the pending store, and issues a
// single-cycle line write into the selected way.
module dcache_refill_writer #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dcache_refill_writer_if.slave  rf
);
    import dcache_pkg::refill_state_t;
    import dcache_pkg::IDLE;
    import dcache_pkg::FILL;
    import dcache_pkg::WRITE;
    import dcache_pkg::way_decode;

    localparam int CNT_W  = $clog2(BEATS);
    localparam int STRB_W = DATA_W / 8;

    typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

    refill_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    line_t               line_q, line_d;
    logic [1:0]          way_q, way_d;
    logic                st_valid_q, st_valid_d;
    logic [CNT_W-1:0]    st_offset_q, st_offset_d;
    logic [DATA_W-1:0]   st_wdata_q, st_wdata_d;
    logic [STRB_W-1:0]   st_wstrb_q, st_wstrb_d;
    line_t               merged;
    logic                write_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            way_q       <= '0;
            st_valid_q  <= 1'b0;
            st_offset_q <= '0;
            st_wdata_q  <= '0;
            st_wstrb_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            way_q       <= way_d;
            st_valid_q  <= st_valid_d;
            st_offset_q <= st_offset_d;
            st_wdata_q  <= st_wdata_d;
            st_wstrb_q  <= st_wstrb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        way_d       = way_q;
        st_valid_d  = st_valid_q;
        st_offset_d = st_offset_q;
        st_wdata_d  = st_wdata_q;
        st_wstrb_d  = st_wstrb_q;
        case (state_q)
            IDLE: begin
                if (rf.refill_start) begin
                    state_d     = FILL;
                    cnt_d       = '0;
                    line_d      = '0;
                    way_d       = way_decode(rf.refill_way);
                    st_valid_d  = rf.st_valid;
                    st_offset_d = rf.st_offset;
                    st_wdata_d  = rf.st_wdata;
                    st_wstrb_d  = rf.st_wstrb;
                end
            end
            FILL: begin
                if (rf.ret_valid) begin
                    line_d[cnt_q] = rf.ret_data;
                    cnt_d         = cnt_q + 1'b1;
                    // The last word always exits, so cnt never wraps while filling.
                    if (rf.ret_last || cnt_q == CNT_W'(BEATS-1)) state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    dcache_store_merge #(.WORD_W(DATA_W), .WORDS(BEATS)) u_merge (
        .line_i   (line_q),
        .offset_i (st_offset_q),
        .wdata_i  (st_wdata_q),
        .wstrb_i  (st_wstrb_q),
        .en_i     (st_valid_q),
        .line_o   (merged)
    );

    assign write_cyc = (state_q == WRITE);
    assign rf.busy   = (state_q != IDLE);
    assign rf.w_en   = write_cyc ? way_q : 2'b00;
    assign rf.w_done = write_cyc;
    assign rf.w_data = write_cyc ? merged : '0;
endmodule
